serial_sub: RTL and testbench
=============================

# serial_sub

Bit-serial N-bit subtractor computing `diff = a - b - bin` LSB-first through one full-subtractor cell and a registered borrow, one bit per clock. It is the inverse-operation companion to the team's ripple adder datapath, for area-constrained arithmetic where a multi-cycle result is acceptable. Operands load on a start pulse; the result is presented with a one-cycle done pulse and held until the next operation.

## Interface
- `WIDTH`, default 8: operand and result width in bits. Legal range is WIDTH ≥ 1.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; sampled only when `busy`=0.
- `a`  in  WIDTH  minuend; captured on the accepted `start` edge.
- `b`  in  WIDTH  subtrahend; captured on the accepted `start` edge.
- `bin`  in  1  borrow-in; captured on the accepted `start` edge.
- `busy`  out  1  high while bits are being processed.
- `done`  out  1  single-cycle pulse: `diff`/`bout` just updated.
- `diff`  out  WIDTH  result `(a - b - bin) mod 2^WIDTH`.
- `bout`  out  1  final borrow: 1 iff a < b + bin (unsigned).

## Operation
- FSM states: IDLE, SHIFT, DONE. Reset state is IDLE.
- **IDLE / DONE, `start`=1 at an edge (accept):**
  - Load shift registers `sa`←a, `sb`←b.
  - Load borrow register `br`←bin.
  - Clear bit counter `cnt`←0.
  - Go to SHIFT.
- **IDLE, `start`=0:** stay in IDLE.
- **DONE, `start`=0:** go to IDLE.
- **SHIFT, each edge:**
  - Full-subtractor cell inputs: x=sa[0], y=sb[0], z=br.
  - d = x^y^z.
  - bo = (~x&y) | (~(x^y)&z).
  - `sa`, `sb` shift right by one.
  - `d` enters the MSB of result shift register `sr`.
  - `br`←bo; `cnt`←cnt+1.
- **SHIFT, edge where cnt == WIDTH-1 (last bit):**
  - `diff`←final `sr` contents, including this bit.
  - `bout`←bo.
  - Go to DONE.
- `start` while in SHIFT is ignored. It is not queued.
- `diff`/`bout` change only on the last-bit edge. They hold their value through IDLE and through subsequent SHIFT cycles.
- `cnt` width is $clog2(WIDTH+1). It never wraps in normal operation.
- Outputs:
  - `busy` = (state==SHIFT).
  - `done` = (state==DONE).
  - Both are decoded from registered state. There are no combinational paths from inputs to outputs.

## Timing
- **Reset values:** `busy`=0, `done`=0, `diff`=0, `bout`=0. State is IDLE; `cnt`, `br`, and all shift registers are 0.
- **Latency:** `start` accepted at edge k.
  - `busy` is high for cycles k..k+WIDTH-1, i.e. WIDTH cycles.
  - `diff`/`bout` update at edge k+WIDTH.
  - `done` is high for exactly the cycle following edge k+WIDTH.
- **Throughput:** a new `start` is accepted during the DONE cycle. Back-to-back operations therefore complete every WIDTH+1 cycles.
- **Reset mid-operation:** `rst_n` low asynchronously aborts the operation.
  - No `done` pulse is produced.
  - `diff`/`bout` return to 0.
  - After `rst_n` deasserts, the first accepted `start` behaves exactly as from power-up.
- **WIDTH=1:** SHIFT lasts one cycle. `done` follows one cycle later.

## Structure
- Sub-module `full_sub`: combinational 1-bit full subtractor (x, y, z → d, bo). It is the exact borrow dual of the team's full-adder cell.
- Shared package/header `arith_pkg`:
  - FSM state encoding (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2).
  - Default width constant.
- All registers live in one clocked block with an asynchronous reset branch. The FSM next-state logic is in a separate combinational block.

## Test plan
- 200 − 55, bin=0, WIDTH=8 → `diff`=145, `bout`=0. `done` pulses exactly 9 cycles after the accepting edge; `busy` is high for exactly 8 cycles.
- 5 − 10, bin=0 → `diff`=251, `bout`=1. Then 0 − 0, bin=1 → `diff`=255, `bout`=1. Then 255 − 255, bin=0 → `diff`=0, `bout`=0.
- `start` held high with changing a/b during SHIFT → the result reflects only the operands captured at acceptance. A new operation starts only in the DONE cycle, giving back-to-back results 9 cycles apart.
- `rst_n` pulsed low at SHIFT cycle 4 → `busy`, `done`, `diff`, `bout` all go to 0 immediately, and no `done` follows. A subsequent 100 − 1 → `diff`=99.
- WIDTH=1 instance → all 8 combinations of (a, b, bin) match the full-subtractor truth table, with `done` 2 cycles after `start`.
- Random self-check → 1000 operands at WIDTH=8 and WIDTH=13 compared against `{bout,diff} = a - b - bin` using a 1-bit-extended reference model.

Source files
------------

// File: rtl/arith_pkg.sv
// Shared arithmetic definitions: FSM state encoding and default operand width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package arith_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/full_sub.sv
// Combinational 1-bit full subtractor: d = x - y - z, bo = borrow out.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
module full_sub (
  input  logic i_x,
  input  logic i_y,
  input  logic i_z,
  output logic o_d,
  output logic o_bo
);

  // Borrow dual of the full-adder cell.
  always_comb begin
    o_d  = i_x ^ i_y ^ i_z;
    o_bo = (~i_x & i_y) | (~(i_x ^ i_y) & i_z);
  end

endmodule

// File: rtl/serial_sub.sv
// Bit-serial subtractor diff = a - b - bin, LSB-first, one bit per clock.
// Latency: WIDTH cycles busy after the accepting edge, done pulses the cycle after.
// Backpressure: start ignored while busy; a new start is accepted in IDLE or the DONE cycle.
module serial_sub
  import arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CW  = $clog2(WIDTH + 1);
  // Partial-result register holds the bits produced before the current one;
  // the current bit is appended when the result is committed.
  localparam int SRW = (WIDTH > 1) ? WIDTH - 1 : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [SRW-1:0]   r_sr;
  logic             r_br;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;

  logic             w_d;
  logic             w_bo;
  logic             w_last;
  logic             w_accept;
  logic [SRW:0]     w_sr_cat;
  logic [WIDTH-1:0] w_result;

  full_sub u_cell (
    .i_x  (r_sa[0]),
    .i_y  (r_sb[0]),
    .i_z  (r_br),
    .o_d  (w_d),
    .o_bo (w_bo)
  );

  assign w_last   = (r_cnt == LAST_CNT);
  assign w_accept = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_sr_cat = {w_d, r_sr};
  assign w_result = w_sr_cat[SRW -: WIDTH];

  // Next-state decode for the IDLE -> SHIFT -> DONE sequence.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_next = ST_SHIFT;
      ST_SHIFT: if (w_last) w_next = ST_DONE;
      ST_DONE:  w_next = start ? ST_SHIFT : ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // All datapath and control state; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_sa    <= '0;
      r_sb    <= '0;
      r_sr    <= '0;
      r_br    <= 1'b0;
      r_cnt   <= '0;
      r_diff  <= '0;
      r_bout  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_sa  <= a;
        r_sb  <= b;
        r_br  <= bin;
        r_cnt <= '0;
      end else if (r_state == ST_SHIFT) begin
        r_sa  <= r_sa >> 1;
        r_sb  <= r_sb >> 1;
        r_sr  <= w_sr_cat[SRW:1];
        r_br  <= w_bo;
        r_cnt <= r_cnt + CW'(1);
        if (w_last) begin
          r_diff <= w_result;
          r_bout <= w_bo;
        end
      end
    end
  end

  assign busy = (r_state == ST_SHIFT);
  assign done = (r_state == ST_DONE);
  assign diff = r_diff;
  assign bout = r_bout;

endmodule

// File: tb/tb_serial_sub.sv
// Scoreboard bench for serial_sub at WIDTH 1, 8 and 13.
// Expected results come from plain extended-width arithmetic on the operands.
// Monitors pop and compare whenever an instance raises done.
module tb_serial_sub;

  typedef struct {
    logic [12:0] diff;
    logic        bout;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  logic        s1, bin1, busy1, done1, bout1;
  logic [0:0]  a1, b1, diff1;
  logic        s8, bin8, busy8, done8, bout8;
  logic [7:0]  a8, b8, diff8;
  logic        s13, bin13, busy13, done13, bout13;
  logic [12:0] a13, b13, diff13;

  exp_t q1[$], q8[$], q13[$];
  exp_t e1, e8, e13;

  serial_sub #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .start(s1), .a(a1), .b(b1), .bin(bin1),
    .busy(busy1), .done(done1), .diff(diff1), .bout(bout1)
  );
  serial_sub #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst_n(rst_n), .start(s8), .a(a8), .b(b8), .bin(bin8),
    .busy(busy8), .done(done8), .diff(diff8), .bout(bout8)
  );
  serial_sub #(.WIDTH(13)) u_w13 (
    .clk(clk), .rst_n(rst_n), .start(s13), .a(a13), .b(b13), .bin(bin13),
    .busy(busy13), .done(done13), .diff(diff13), .bout(bout13)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic spurious(input string name);
    checks++;
    errors++;
    $display("FAIL %s done with empty scoreboard (cycle %0d)", name, cyc);
  endtask

  // Drive an operation onto instance w and queue its expected result.
  task automatic issue(input int w, input logic [12:0] av_in, input logic [12:0] bv_in, input logic bi);
    exp_t e;
    logic [13:0] ext;
    logic [12:0] mask;
    logic [12:0] av, bv;
    mask = 13'((14'd1 << w) - 14'd1);
    av = av_in & mask;
    bv = bv_in & mask;
    ext = {1'b0, av} - {1'b0, bv} - 14'(bi);
    e.diff = ext[12:0] & mask;
    e.bout = ext[w];
    e.cyc  = cyc + 1 + w;
    case (w)
      1: begin a1 = av[0:0]; b1 = bv[0:0]; bin1 = bi; s1 = 1'b1; q1.push_back(e); end
      8: begin a8 = av[7:0]; b8 = bv[7:0]; bin8 = bi; s8 = 1'b1; q8.push_back(e); end
      default: begin a13 = av; b13 = bv; bin13 = bi; s13 = 1'b1; q13.push_back(e); end
    endcase
  endtask

  task automatic drop(input int w);
    case (w)
      1: s1 = 1'b0;
      8: s8 = 1'b0;
      default: s13 = 1'b0;
    endcase
  endtask

  // Caller sits at a negedge; returns at the negedge of the done cycle.
  task automatic run_op(input int w, input logic [12:0] av, input logic [12:0] bv, input logic bi);
    issue(w, av, bv, bi);
    @(negedge clk);
    drop(w);
    repeat (w) @(negedge clk);
  endtask

  // Monitors: compare each done against the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done1 === 1'b1) begin
      if (q1.size() == 0) spurious("w1_done");
      else begin
        e1 = q1.pop_front();
        chk("w1_diff", 32'(diff1), 32'(e1.diff));
        chk("w1_bout", 32'(bout1), 32'(e1.bout));
        chk("w1_done_cycle", cyc, e1.cyc);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1 && done8 === 1'b1) begin
      if (q8.size() == 0) spurious("w8_done");
      else begin
        e8 = q8.pop_front();
        chk("w8_diff", 32'(diff8), 32'(e8.diff));
        chk("w8_bout", 32'(bout8), 32'(e8.bout));
        chk("w8_done_cycle", cyc, e8.cyc);
        chk("w8_busy_at_done", 32'(busy8), 32'd0);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1 && done13 === 1'b1) begin
      if (q13.size() == 0) spurious("w13_done");
      else begin
        e13 = q13.pop_front();
        chk("w13_diff", 32'(diff13), 32'(e13.diff));
        chk("w13_bout", 32'(bout13), 32'(e13.bout));
        chk("w13_done_cycle", cyc, e13.cyc);
      end
    end
  end

  initial begin
    int nb;
    s1 = 0; s8 = 0; s13 = 0;
    a1 = '0; b1 = '0; bin1 = 0;
    a8 = '0; b8 = '0; bin8 = 0;
    a13 = '0; b13 = '0; bin13 = 0;

    // Reset values
    #3;
    chk("rst_busy8", 32'(busy8), 0);
    chk("rst_done8", 32'(done8), 0);
    chk("rst_diff8", 32'(diff8), 0);
    chk("rst_bout8", 32'(bout8), 0);
    chk("rst_diff13", 32'(diff13), 0);
    chk("rst_done1", 32'(done1), 0);
    #10 rst_n = 1'b1;
    @(negedge clk);

    // 200 - 55: busy for exactly 8 cycles, done at k+8 (checked by monitor)
    issue(8, 13'd200, 13'd55, 1'b0);
    @(negedge clk);
    drop(8);
    nb = 0;
    for (int j = 0; j <= 8; j++) begin
      if (j > 0) @(negedge clk);
      nb += int'(busy8);
    end
    chk("w8_busy_cycles", nb, 8);

    // Directed corner cases, back-to-back through the DONE cycle
    run_op(8, 13'd5, 13'd10, 1'b0);
    run_op(8, 13'd0, 13'd0, 1'b1);
    run_op(8, 13'd255, 13'd255, 1'b0);

    // start held high with operands changing during SHIFT
    for (int i = 0; i < 27; i++) begin
      if (i % 9 == 0) issue(8, 13'($urandom), 13'($urandom), 1'($urandom));
      else begin
        a8 = 8'($urandom);
        b8 = 8'($urandom);
        bin8 = 1'($urandom);
      end
      @(negedge clk);
    end
    s8 = 1'b0;
    @(negedge clk);

    // Leave a nonzero result held, then abort an operation at SHIFT cycle 4
    run_op(8, 13'd7, 13'd3, 1'b0);
    issue(8, 13'd100, 13'd50, 1'b0);
    @(negedge clk);
    drop(8);
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_busy8", 32'(busy8), 0);
    chk("abort_done8", 32'(done8), 0);
    chk("abort_diff8", 32'(diff8), 0);
    chk("abort_bout8", 32'(bout8), 0);
    q8.delete();
    #2 rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("post_abort_diff8", 32'(diff8), 0);
    run_op(8, 13'd100, 13'd1, 1'b0);

    // WIDTH=1 truth table
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      run_op(1, 13'(v[2]), 13'(v[1]), v[0]);
    end

    // Randomized operands at WIDTH 8 and 13, with occasional idle gaps
    for (int n = 0; n < 1000; n++) begin
      if ($urandom_range(0, 3) == 0) @(negedge clk);
      run_op(8, 13'($urandom), 13'($urandom), 1'($urandom));
    end
    for (int n = 0; n < 1000; n++) begin
      if ($urandom_range(0, 3) == 0) @(negedge clk);
      run_op(13, 13'($urandom), 13'($urandom), 1'($urandom));
    end

    repeat (20) @(negedge clk);
    chk("w1_queue_drained", q1.size(), 0);
    chk("w8_queue_drained", q8.size(), 0);
    chk("w13_queue_drained", q13.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
